pc_sequencer: RTL

- Next-PC controller for the fetch-stage PC register. Each cycle it selects the next PC from:
  - sequential PC+4,
  - execute-stage branch/jump redirect,
  - trap redirect.
- Drives the PC register's stall and next-PC inputs, plus decode/execute flushes.
- A redirect that arrives during a fetch stall is buffered so it is never lost. The block also supports halt/resume for debug.

---
 rtl/core_pkg.sv | 17 +
 rtl/pcseq_redirect_buf.sv | 44 ++++
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the fetch-stage PC sequencer.
//   pcseq_state_e : sequencer FSM states
//   INSTR_BYTES   : sequential PC increment
//   RESET_VEC_DEF : default first fetch address after reset
package core_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    HALTED
  } pcseq_state_e;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [63:0] RESET_VEC_DEF = 64'h0;

endpackage

// File: rtl/pcseq_redirect_buf.sv
// Pending-redirect register: holds one redirect captured while fetch is stalled.
// A trap-class entry is sticky; a branch entry may be replaced by any new
// candidate (trap or branch).
//   clk, rst         : clock, async active-low reset
//   cap_en           : capture window (fetch stalled in RUN/HOLD)
//   clr              : pending entry has been applied, drop it
//   cand_*           : this cycle's redirect candidate
//   pend_*           : stored entry
//   load_c           : candidate is being written this cycle
module pcseq_redirect_buf #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap_en,
  input  logic            clr,
  input  logic            cand_valid,
  input  logic [XLEN-1:0] cand_target,
  input  logic            cand_is_trap,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target,
  output logic            pend_is_trap,
  output logic            load_c
);

  // Only an empty slot or a branch entry accepts a new candidate.
  assign load_c = cap_en & cand_valid & (~pend_valid | ~pend_is_trap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid   <= 1'b0;
      pend_target  <= '0;
      pend_is_trap <= 1'b0;
    end else if (clr) begin
      pend_valid   <= 1'b0;
      pend_is_trap <= 1'b0;
    end else if (load_c) begin
      pend_valid   <= 1'b1;
      pend_target  <= cand_target;
      pend_is_trap <= cand_is_trap;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch-stage PC register.
// Selects PC+4, execute redirect or trap redirect; buffers redirects that
// arrive while fetch is stalled; supports debug halt/resume.
//   clk, rst                 : clock, async active-low reset
//   PCF                      : current PC
//   StallF_in                : hazard-unit fetch stall
//   PCSrcE, PCTargetE        : execute-stage taken branch/jump and target
//   trap_req, trap_vec       : trap redirect request and handler address
//   halt_req, resume_req     : debug halt/resume levels
//   PCnext, StallF           : to the PC register
//   FlushD, FlushE           : pipeline flushes
//   misalign_o               : misaligned branch target pulse
//   halted                   : high while halted
//   redirect_cnt             : saturating count of applied redirects
module pc_sequencer
  import core_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  PCF,
  input  logic             StallF_in,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic [XLEN-1:0]  PCnext,
  output logic             StallF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             misalign_o,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  pcseq_state_e state, state_n;

  logic            cand_valid;
  logic            cand_mis;
  logic            cand_is_trap;
  logic [XLEN-1:0] cand_target;

  logic            cap_en;
  logic            clr;
  logic            apply;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;
  logic            pend_is_trap;
  logic            buf_load;

  // Redirect candidate: trap first, then branch; a misaligned branch target
  // is turned into a trap-class redirect to trap_vec.
  always_comb begin
    cand_valid   = trap_req | PCSrcE;
    cand_mis     = ~trap_req & PCSrcE & (PCTargetE[1:0] != 2'b00);
    cand_is_trap = trap_req | cand_mis;
    cand_target  = cand_is_trap ? trap_vec : PCTargetE;
  end

  pcseq_redirect_buf #(
    .XLEN (XLEN)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .cap_en       (cap_en),
    .clr          (clr),
    .cand_valid   (cand_valid),
    .cand_target  (cand_target),
    .cand_is_trap (cand_is_trap),
    .pend_valid   (pend_valid),
    .pend_target  (pend_target),
    .pend_is_trap (pend_is_trap),
    .load_c       (buf_load)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_n    = state;
    PCnext     = PCF;
    StallF     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    misalign_o = 1'b0;
    halted     = 1'b0;
    apply      = 1'b0;
    cap_en     = 1'b0;
    clr        = 1'b0;

    unique case (state)
      BOOT: begin
        PCnext  = RESET_VEC;
        FlushD  = 1'b1;
        state_n = RUN;
      end

      RUN: begin
        if (StallF_in) begin
          StallF     = 1'b1;
          cap_en     = 1'b1;
          misalign_o = cand_mis;
          if (cand_valid) state_n = HOLD;
        end else if (cand_valid) begin
          PCnext     = cand_target;
          FlushD     = 1'b1;
          FlushE     = cand_is_trap;
          misalign_o = cand_mis;
          apply      = 1'b1;
        end else begin
          PCnext = PCF + XLEN'(INSTR_BYTES);
          if (halt_req) begin
            StallF  = 1'b1;
            state_n = HALTED;
          end
        end
      end

      HOLD: begin
        PCnext = pend_target;
        StallF = StallF_in;
        if (StallF_in) begin
          cap_en     = 1'b1;
          misalign_o = cand_mis & buf_load;
        end else begin
          FlushD  = pend_valid;
          FlushE  = pend_valid & pend_is_trap;
          apply   = pend_valid;
          clr     = 1'b1;
          state_n = RUN;
        end
      end

      HALTED: begin
        StallF = 1'b1;
        halted = 1'b1;
        if (trap_req) begin
          PCnext  = trap_vec;
          StallF  = 1'b0;
          FlushD  = 1'b1;
          FlushE  = 1'b1;
          apply   = 1'b1;
          state_n = RUN;
        end else if (resume_req) begin
          state_n = RUN;
        end
      end

      default: state_n = BOOT;
    endcase

    // Outputs sit at their reset values while reset is asserted.
    if (!rst) begin
      PCnext     = RESET_VEC;
      StallF     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      misalign_o = 1'b0;
      halted     = 1'b0;
      apply      = 1'b0;
      cap_en     = 1'b0;
      clr        = 1'b0;
    end
  end

  // Saturating applied-redirect counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_cnt <= '0;
    end else if (apply && (redirect_cnt != '1)) begin
      redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule
